pll_rst_sequencer: RTL and testbench
====================================

Name: pll_rst_sequencer

Overview:
- Sits directly downstream of pll_wrapper. Consumes its asynchronous `locked` output and drives the PLL's `resetn`.
- Produces staged, synchronous-deassert active-low resets for downstream logic in the PLL output clock domain.
- Runs a lock watchdog that re-resets the PLL on timeout. Counts lock-loss events for status.

Parameters:
- NUM_STAGES, 3: number of staged reset outputs; min 1.
- PLL_RST_CYCLES, 4: cycles `pll_resetn_o` is held low per PLL reset attempt; min 1.
- LOCK_TIMEOUT, 1000: cycles allowed in WAIT_LOCK before a retry; min 2.
- STABLE_CYCLES, 16: consecutive synchronized-lock cycles required before release; min 1.
- STAGE_DELAY, 8: cycles between successive stage releases, and from last stage to `sys_ready`; min 1.
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- clk_in, input, 1: block clock (free-running reference-derived clock, e.g. a PLL output or board clock).
- resetn, input, 1: asynchronous, active-low reset.
- locked, input, 1: PLL lock status; asynchronous to clk_in.
- clear_status, input, 1: synchronous; clears `lock_timeout` and `loss_cnt`.
- pll_resetn_o, output, 1: active-low reset to pll_wrapper.
- rst_n_stage, output, NUM_STAGES: active-low staged resets; bit 0 is released first.
- sys_ready, output, 1: high once all stages are released and lock is held.
- lock_timeout, output, 1: sticky flag, set on any watchdog expiry.
- loss_cnt, output, LOSS_CNT_W: saturating count of lock-loss events after release began.

Behaviour:
- Reset values: `pll_resetn_o`=0, `rst_n_stage`=all 0, `sys_ready`=0, `lock_timeout`=0, `loss_cnt`=0, state=PLL_RST, all counters 0. Every output is registered.
- `locked` passes through a 2-FF synchronizer producing `lock_s`. That adds 2 cycles of latency; all decisions use `lock_s`.
- A single cycle counter `cnt` is cleared on every state entry.
- PLL_RST:
  - `pll_resetn_o`=0.
  - When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK. `pll_resetn_o` goes to 1 on that same edge.
- WAIT_LOCK:
  - If `lock_s`=1, go to LOCK_STABLE.
  - Otherwise, when cnt==LOCK_TIMEOUT-1, set `lock_timeout`=1 and go to PLL_RST.
- LOCK_STABLE:
  - If `lock_s`=0, go to WAIT_LOCK. No loss count in this state.
  - When cnt==STABLE_CYCLES-1 with `lock_s`=1, go to RELEASE; `rst_n_stage[0]`=1 on that edge.
- RELEASE:
  - Stage k (k≥1) is released exactly k*STAGE_DELAY cycles after stage 0.
  - STAGE_DELAY cycles after the last stage is released, `sys_ready`=1 and the state becomes RUN.
- RUN: outputs hold.
- Lock loss in RELEASE or RUN (`lock_s`=0), all on the next edge:
  - `rst_n_stage`=all 0 and `sys_ready`=0.
  - `loss_cnt` increments, saturating at all-ones.
  - State goes to WAIT_LOCK. The PLL is not reset.
- `clear_status` has priority over a same-cycle set or increment: the result is 0.
- Stage outputs only ever deassert in ascending order and assert all together.
- `resetn` low mid-operation immediately forces all reset values asynchronously. Deassertion takes effect on the next clk_in edge.
- Counter widths are `$clog2` of the largest parameter used, +1. No counter wraps; each is bounded by its state exit.

Decomposition:
- Package pll_rst_pkg:
  - `typedef enum logic [2:0]` for states: PLL_RST, WAIT_LOCK, LOCK_STABLE, RELEASE, RUN.
  - Default-parameter localparams.
  - A function computing the counter width.
- Sub-module sync_2ff: 1-bit, two-flop synchronizer with async active-low reset to 0. Reused for `locked`.

Test Plan:
- Power-up: `resetn` low 20 ns, then high; `locked` rises 100 ns later.
  - `pll_resetn_o` rises on the 4th edge after reset release.
  - `rst_n_stage[0]` releases 2+16 cycles after `locked` is sampled.
  - Stage 1 releases 8 cycles after stage 0; stage 2 releases 16 cycles after stage 0.
  - `sys_ready` rises 24 cycles after stage 0.
- Lock never asserts: `lock_timeout`=1 after 4+1000 cycles. `pll_resetn_o` then pulses low for 4 cycles, and the sequence repeats.
- Glitch during LOCK_STABLE: `locked` high 10 cycles then low 1 cycle, then high.
  - No stage is released, `loss_cnt`=0.
  - Release occurs 16 stable cycles after the recovery.
- Lock loss in RUN: drop `locked` for 5 cycles.
  - All `rst_n_stage`=0 and `sys_ready`=0 within 3 cycles; `loss_cnt`=1.
  - Full re-release follows, without a `pll_resetn_o` pulse.
- Status handling: with LOSS_CNT_W=2, cause 5 losses, then pulse `clear_status`.
  - `loss_cnt` reads 1, 2, 3, 3, 3, then 0; `lock_timeout` clears.
- Async reset mid-RELEASE: drop `resetn` after stage 0 is released.
  - All outputs are at reset values immediately, without a clock edge.
  - The full sequence restarts from PLL_RST.

Source files
------------

// File: rtl/pll_rst_sequencer_pkg.sv
// Shared types, default parameters and sizing helpers for the PLL reset sequencer.
//
// Contents:
//   state_e       - sequencer FSM states
//   Def*          - default parameter values used by pll_rst_sequencer
//   max_u()       - larger of two unsigned values
//   cnt_width()   - width of a down-stream cycle counter that must reach max_val
package pll_rst_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StLockStable,
    StRelease,
    StRun
  } state_e;

  localparam int unsigned DefNumStages   = 3;
  localparam int unsigned DefPllRstCycles = 4;
  localparam int unsigned DefLockTimeout = 1000;
  localparam int unsigned DefStableCycles = 16;
  localparam int unsigned DefStageDelay  = 8;
  localparam int unsigned DefLossCntW    = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit above $clog2 so the counter can always hold max_val itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return int'($clog2(max_val)) + 1;
  endfunction

endpackage

// File: rtl/pll_rst_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset to 0.
//
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - input synchronized to clk_i (two cycles of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL reset sequencer. Drives the PLL reset, waits for a stable lock, then releases
// a set of active-low resets one stage at a time. A watchdog re-resets the PLL when
// lock does not arrive in time; lock loss after release re-asserts all stages without
// touching the PLL and is counted for status.
//
// Ports:
//   clk_in        - block clock
//   resetn        - asynchronous active-low reset
//   locked        - PLL lock, asynchronous to clk_in
//   clear_status  - synchronous clear of lock_timeout and loss_cnt (wins over set/inc)
//   pll_resetn_o  - active-low reset to the PLL
//   rst_n_stage   - staged active-low resets, bit 0 released first
//   sys_ready     - all stages released and lock held
//   lock_timeout  - sticky watchdog expiry flag
//   loss_cnt      - saturating count of lock-loss events after release began
module pll_rst_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = DefNumStages,
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES  = DefStableCycles,
  parameter int unsigned STAGE_DELAY    = DefStageDelay,
  parameter int unsigned LOSS_CNT_W     = DefLossCntW
) (
  input  logic                  clk_in,
  input  logic                  resetn,
  input  logic                  locked,
  input  logic                  clear_status,
  output logic                  pll_resetn_o,
  output logic [NUM_STAGES-1:0] rst_n_stage,
  output logic                  sys_ready,
  output logic                  lock_timeout,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  // RELEASE lasts until sys_ready: one STAGE_DELAY per stage.
  localparam int unsigned RelCycles = NUM_STAGES * STAGE_DELAY;
  localparam int unsigned CntMax    = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                            max_u(STABLE_CYCLES, RelCycles));
  localparam int unsigned CntW      = cnt_width(CntMax);

  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] ReleaseLast = CntW'(RelCycles - 1);

  logic lock_s;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    pll_resetn_q, pll_resetn_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    ready_q, ready_d;
  logic                    timeout_q, timeout_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    timeout_set;
  logic                    loss_inc;

  sync_2ff u_lock_sync (
    .clk_i  (clk_in),
    .rst_ni (resetn),
    .d_i    (locked),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    stage_d     = stage_q;
    ready_d     = ready_q;
    timeout_set = 1'b0;
    loss_inc    = 1'b0;

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == PllRstLast) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StLockStable;
        end else if (cnt_q == TimeoutLast) begin
          timeout_set = 1'b1;
          state_d     = StPllRst;
        end
      end
      StLockStable: begin
        // A drop here is a pre-release glitch: restart the wait, do not count it.
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d    = StRelease;
          stage_d[0] = 1'b1;
        end
      end
      StRelease: begin
        if (!lock_s) begin
          stage_d  = '0;
          ready_d  = 1'b0;
          loss_inc = 1'b1;
          state_d  = StWaitLock;
        end else begin
          // cnt is 0 on the edge after stage 0 went high, so stage k lands at
          // k*STAGE_DELAY cycles after stage 0.
          for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            if (cnt_q == CntW'(k * STAGE_DELAY - 1)) begin
              stage_d[k] = 1'b1;
            end
          end
          if (cnt_q == ReleaseLast) begin
            ready_d = 1'b1;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          stage_d  = '0;
          ready_d  = 1'b0;
          loss_inc = 1'b1;
          state_d  = StWaitLock;
        end
      end
      default: begin
        state_d = StPllRst;
        stage_d = '0;
        ready_d = 1'b0;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // PLL reset is low exactly while the next state is PLL_RST.
    pll_resetn_d = (state_d != StPllRst);

    if (clear_status) begin
      timeout_d = 1'b0;
      loss_d    = '0;
    end else begin
      timeout_d = timeout_q | timeout_set;
      loss_d    = (loss_inc && (loss_q != '1)) ? loss_q + LOSS_CNT_W'(1) : loss_q;
    end
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StPllRst;
      cnt_q        <= '0;
      pll_resetn_q <= 1'b0;
      stage_q      <= '0;
      ready_q      <= 1'b0;
      timeout_q    <= 1'b0;
      loss_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_resetn_q <= pll_resetn_d;
      stage_q      <= stage_d;
      ready_q      <= ready_d;
      timeout_q    <= timeout_d;
      loss_q       <= loss_d;
    end
  end

  assign pll_resetn_o = pll_resetn_q;
  assign rst_n_stage  = stage_q;
  assign sys_ready    = ready_q;
  assign lock_timeout = timeout_q;
  assign loss_cnt     = loss_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Self-checking bench for pll_rst_sequencer. Expected output transitions (signal,
// value, cycle) are queued when stimulus is driven; a monitor queues observed
// transitions and the two are compared in order.
module tb_pll_rst_sequencer;

  localparam int unsigned NS      = 3;
  localparam int unsigned LW      = 2;
  localparam int          LossMax = (1 << LW) - 1;

  localparam int SigPll   = 0;
  localparam int SigStage = 1;
  localparam int SigReady = 2;
  localparam int SigTo    = 3;
  localparam int SigLoss  = 4;

  logic          clk_in;
  logic          resetn;
  logic          locked;
  logic          clear_status;
  logic          pll_resetn_o;
  logic [NS-1:0] rst_n_stage;
  logic          sys_ready;
  logic          lock_timeout;
  logic [LW-1:0] loss_cnt;

  pll_rst_sequencer #(
    .NUM_STAGES     (NS),
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (1000),
    .STABLE_CYCLES  (16),
    .STAGE_DELAY    (8),
    .LOSS_CNT_W     (LW)
  ) dut (
    .clk_in       (clk_in),
    .resetn       (resetn),
    .locked       (locked),
    .clear_status (clear_status),
    .pll_resetn_o (pll_resetn_o),
    .rst_n_stage  (rst_n_stage),
    .sys_ready    (sys_ready),
    .lock_timeout (lock_timeout),
    .loss_cnt     (loss_cnt)
  );

  typedef struct {
    int sig;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;

  logic          m_pll;
  logic [NS-1:0] m_stage;
  logic          m_ready;
  logic          m_to;
  logic [LW-1:0] m_loss;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    forever begin
      @(posedge clk_in);
      cyc++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic string sig_name(input int s);
    case (s)
      SigPll:   return "pll_resetn_o";
      SigStage: return "rst_n_stage";
      SigReady: return "sys_ready";
      SigTo:    return "lock_timeout";
      SigLoss:  return "loss_cnt";
      default:  return "unknown";
    endcase
  endfunction

  task automatic push_exp(input int s, input int v, input int c);
    ev_t e;
    e.sig = s;
    e.val = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_obs(input int s, input int v);
    ev_t e;
    e.sig = s;
    e.val = v;
    e.cyc = cyc;
    obs_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, records every output change.
  initial begin
    m_pll   = 1'b0;
    m_stage = '0;
    m_ready = 1'b0;
    m_to    = 1'b0;
    m_loss  = '0;
    forever begin
      @(negedge clk_in);
      if (pll_resetn_o !== m_pll) begin
        push_obs(SigPll, int'(pll_resetn_o));
        m_pll = pll_resetn_o;
      end
      if (rst_n_stage !== m_stage) begin
        push_obs(SigStage, int'(rst_n_stage));
        m_stage = rst_n_stage;
      end
      if (sys_ready !== m_ready) begin
        push_obs(SigReady, int'(sys_ready));
        m_ready = sys_ready;
      end
      if (lock_timeout !== m_to) begin
        push_obs(SigTo, int'(lock_timeout));
        m_to = lock_timeout;
      end
      if (loss_cnt !== m_loss) begin
        push_obs(SigLoss, int'(loss_cnt));
        m_loss = loss_cnt;
      end
    end
  end

  task automatic wait_until(input int c);
    do begin
      @(negedge clk_in);
    end while (cyc < c);
  endtask

  task automatic drain(input int budget);
    ev_t e;
    ev_t o;
    int  n = 0;
    while ((obs_q.size() < exp_q.size()) && (n < budget)) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    #1;
    check_eq("event_count", obs_q.size(), exp_q.size());
    while ((exp_q.size() > 0) && (obs_q.size() > 0)) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq("event_signal", o.sig, e.sig);
      check_eq($sformatf("%s_value", sig_name(e.sig)), o.val, e.val);
      check_eq($sformatf("%s_cycle", sig_name(e.sig)), o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int r;
    int l;
    int a;
    int g;
    int d;
    int c;
    int loss_m;

    resetn       = 1'b1;
    locked       = 1'b0;
    clear_status = 1'b0;
    #1 resetn = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);

    check_eq("rst_pll_resetn", pll_resetn_o, 0);
    check_eq("rst_stage", rst_n_stage, 0);
    check_eq("rst_sys_ready", sys_ready, 0);
    check_eq("rst_lock_timeout", lock_timeout, 0);
    check_eq("rst_loss_cnt", loss_cnt, 0);

    // Power-up with lock arriving 100 ns after reset release.
    r = cyc;
    resetn = 1'b1;
    push_exp(SigPll, 1, r + 4);
    wait_until(r + 10);
    l = cyc;
    locked = 1'b1;
    push_exp(SigStage, 1, l + 19);
    push_exp(SigStage, 3, l + 27);
    push_exp(SigStage, 7, l + 35);
    push_exp(SigReady, 1, l + 43);
    wait_until(l + 46);
    drain(20);

    // Async reset from RUN, restart with lock held, async reset again after stage 0.
    @(negedge clk_in);
    a = cyc;
    #2 resetn = 1'b0;
    push_exp(SigPll, 0, a + 1);
    push_exp(SigStage, 0, a + 1);
    push_exp(SigReady, 0, a + 1);
    wait_until(a + 3);
    r = cyc;
    resetn = 1'b1;
    push_exp(SigPll, 1, r + 4);
    push_exp(SigStage, 1, r + 21);
    wait_until(r + 23);
    a = cyc;
    #2 resetn = 1'b0;
    #1;
    check_eq("async_pll_resetn", pll_resetn_o, 0);
    check_eq("async_stage", rst_n_stage, 0);
    check_eq("async_sys_ready", sys_ready, 0);
    check_eq("async_lock_timeout", lock_timeout, 0);
    check_eq("async_loss_cnt", loss_cnt, 0);
    push_exp(SigPll, 0, a + 1);
    push_exp(SigStage, 0, a + 1);
    locked = 1'b0;
    wait_until(a + 3);
    drain(10);

    // Lock never arrives: watchdog fires, PLL reset pulses for 4 cycles.
    @(negedge clk_in);
    r = cyc;
    resetn = 1'b1;
    push_exp(SigPll, 1, r + 4);
    push_exp(SigPll, 0, r + 1004);
    push_exp(SigTo, 1, r + 1004);
    push_exp(SigPll, 1, r + 1008);
    wait_until(r + 1010);
    check_eq("timeout_flag", lock_timeout, 1);

    // One-cycle glitch while lock is settling: no release, no loss count.
    g = cyc;
    locked = 1'b1;
    wait_until(g + 10);
    locked = 1'b0;
    wait_until(g + 11);
    locked = 1'b1;
    push_exp(SigStage, 1, g + 30);
    push_exp(SigStage, 3, g + 38);
    push_exp(SigStage, 7, g + 46);
    push_exp(SigReady, 1, g + 54);
    wait_until(g + 20);
    check_eq("glitch_no_release", rst_n_stage, 0);
    check_eq("glitch_loss_cnt", loss_cnt, 0);
    wait_until(g + 56);
    drain(10);

    // Five lock losses in RUN; counter saturates at all-ones.
    loss_m = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      d = cyc;
      locked = 1'b0;
      push_exp(SigStage, 0, d + 3);
      push_exp(SigReady, 0, d + 3);
      if (loss_m < LossMax) begin
        loss_m++;
        push_exp(SigLoss, loss_m, d + 3);
      end
      wait_until(d + 5);
      locked = 1'b1;
      push_exp(SigStage, 1, d + 24);
      push_exp(SigStage, 3, d + 32);
      push_exp(SigStage, 7, d + 40);
      push_exp(SigReady, 1, d + 48);
      wait_until(d + 50);
      drain(10);
      check_eq("loss_cnt_value", loss_cnt, loss_m);
    end

    // Status clear.
    @(negedge clk_in);
    c = cyc;
    clear_status = 1'b1;
    @(negedge clk_in);
    clear_status = 1'b0;
    push_exp(SigTo, 0, c + 1);
    push_exp(SigLoss, 0, c + 1);
    wait_until(c + 3);
    drain(10);
    check_eq("clear_loss_cnt", loss_cnt, 0);
    check_eq("clear_lock_timeout", lock_timeout, 0);
    check_eq("run_sys_ready", sys_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
